// File: rtl/tx_arbiter.sv
// Two-requester arbiter that sequences write / send-cell / send-row / send-all
// operations onto a single transmitter port, one cell per ISSUE.
module tx_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [2:0] addr0,
    input  logic [2:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] t_data,
    output logic       t_row,
    output logic [1:0] t_col,
    output logic [2:0] t_action,
    input  logic       t_busy,
    output logic       seq_busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t     state, state_nxt;
    logic       ptr, gnt, gnt_nxt, grant;
    logic [1:0] op_q;
    logic [2:0] addr_q, idx;
    logic [7:0] data_q;
    logic [1:0] tmo_cnt;
    logic       timeout, cell_done, last_cell;
    logic       cell_row;
    logic [1:0] cell_col;
    logic       ack0_nxt, ack1_nxt, done0_nxt, done1_nxt, busy_nxt;
    logic [2:0] act_nxt;

    // Tie goes to the pointer; otherwise whichever single requester is up.
    always_comb begin
        grant     = (state == IDLE) && (req0 || req1);
        gnt_nxt   = (req0 && req1) ? ptr : req1;
        timeout   = (state == WAIT_HI) && !t_busy && (tmo_cnt == 2'd3);
        cell_done = timeout || ((state == WAIT_LO) && !t_busy);
        case (op_q)
            2'b10:   last_cell = (idx[1:0] == 2'd3);
            2'b11:   last_cell = (idx == 3'd7);
            default: last_cell = 1'b1;
        endcase
        case (op_q)
            2'b10:   begin cell_row = addr_q[2]; cell_col = idx[1:0];    end
            2'b11:   begin cell_row = idx[2];    cell_col = idx[1:0];    end
            default: begin cell_row = addr_q[2]; cell_col = addr_q[1:0]; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = (op_q == 2'b00) ? DONE : WAIT_HI;
            WAIT_HI: begin
                if (t_busy)       state_nxt = WAIT_LO;
                else if (timeout) state_nxt = last_cell ? DONE : ISSUE;
            end
            WAIT_LO: if (!t_busy) state_nxt = last_cell ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack0_nxt  = grant && !gnt_nxt;
        ack1_nxt  = grant && gnt_nxt;
        done0_nxt = (state == DONE) && !gnt;
        done1_nxt = (state == DONE) && gnt;
        act_nxt   = 3'd0;
        if (state == ISSUE) act_nxt = (op_q == 2'b00) ? 3'd1 : 3'd2;
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack0 <= 1'b0; ack1 <= 1'b0; done0 <= 1'b0; done1 <= 1'b0;
            t_action <= 3'd0; t_data <= 8'd0; t_row <= 1'b0; t_col <= 2'd0;
            seq_busy <= 1'b0; ptr <= 1'b0; gnt <= 1'b0; idx <= 3'd0;
            op_q <= 2'd0; addr_q <= 3'd0; data_q <= 8'd0; tmo_cnt <= 2'd0;
        end else begin
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            done0    <= done0_nxt;
            done1    <= done1_nxt;
            t_action <= act_nxt;
            seq_busy <= busy_nxt;
            if (grant) begin
                gnt    <= gnt_nxt;
                op_q   <= gnt_nxt ? op1   : op0;
                addr_q <= gnt_nxt ? addr1 : addr0;
                data_q <= gnt_nxt ? data1 : data0;
                idx    <= 3'd0;
            end
            if (state == ISSUE) begin
                t_row   <= cell_row;
                t_col   <= cell_col;
                t_data  <= data_q;
                tmo_cnt <= 2'd0;
            end
            if ((state == WAIT_HI) && !t_busy) tmo_cnt <= tmo_cnt + 2'd1;
            // Last cell never increments, so op 11 stops at index 7.
            if (cell_done && !last_cell) idx <= idx + 3'd1;
            if (state == DONE) ptr <= ~gnt;
        end
    end

endmodule
